// File: rtl/frame_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_pkg
//  Description : Shared defaults, grant encoding and arbiter state encoding
//                for the frame buffer arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_buf_pkg;

    localparam int DEPTH_DEF = 3444;   // memory words per frame
    localparam int AW_DEF    = 12;     // address width, 2**AW >= DEPTH
    localparam int DW_DEF    = 2048;   // memory word width

    // Which requester owns the memory in a given cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GNT_WR = 2'd1,
        ST_GNT_RD = 2'd2
    } arb_state_e;

    function automatic grant_e state_to_grant(input arb_state_e s);
        grant_e g;
        case (s)
            ST_GNT_WR: g = GNT_WR;
            ST_GNT_RD: g = GNT_RD;
            default:   g = GNT_NONE;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buf_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_arbiter_if
//  Description : Writer handshake, reader request/valid, memory port and
//                status signals of the frame buffer arbiter.
//                slave  : the arbiter side.
//                master : requesters + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface frame_buf_arbiter_if #(
    parameter int AW = frame_buf_pkg::AW_DEF,
    parameter int DW = frame_buf_pkg::DW_DEF
) ();
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          ovf_err;

    modport slave (
        input  flush, wr_valid, wr_data, rd_req, mem_rdata,
        output wr_ready, rd_valid, rd_data, mem_en, mem_we, mem_addr,
               mem_wdata, count, full, empty, ovf_err
    );

    modport master (
        output flush, wr_valid, wr_data, rd_req, mem_rdata,
        input  wr_ready, rd_valid, rd_data, mem_en, mem_we, mem_addr,
               mem_wdata, count, full, empty, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/wrap_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : wrap_ptr
//  Description : AW-bit circular address counter. Increments on i_inc,
//                wraps from DEPTH-1 to 0 (DEPTH need not be a power of two),
//                synchronous clear on i_clr (clear wins).
//  Ports       : clk, reset_n (async, active-low), i_clr, i_inc, o_ptr
//  Revision    : 1.0 - initial release
// ============================================================================
module wrap_ptr #(
    parameter int DEPTH = 3444,
    parameter int AW    = 12
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          i_clr,
    input  wire logic          i_inc,
    output logic      [AW-1:0] o_ptr
);
    localparam logic [AW-1:0] C_LAST = AW'(DEPTH - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ptr <= '0;
        end else if (i_clr) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            o_ptr <= (o_ptr == C_LAST) ? '0 : o_ptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/frame_buf_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_arbiter
//  Description : Shares one single-port synchronous frame memory between a
//                writer (valid/ready) and a FIFO-order reader (request/valid).
//                Owns circular write/read pointers, occupancy, and
//                round-robin arbitration. Read data arrives one cycle after
//                the read grant.
//  Ports       : clk, reset_n (async, active-low)
//                bus (slave): flush, wr_valid/wr_data/wr_ready,
//                rd_req/rd_valid/rd_data, mem_en/mem_we/mem_addr/mem_wdata,
//                mem_rdata, count/full/empty, ovf_err
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    frame_buf_arbiter_if.slave bus
);
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    grant_e        r_last_grant;
    grant_e        w_grant;
    logic [AW:0]   r_count;
    logic          r_ovf_err;
    logic [AW-1:0] r_addr_q;
    logic [DW-1:0] r_wdata_q;
    logic [AW-1:0] w_wr_ptr;
    logic [AW-1:0] w_rd_ptr;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_wdata;
    logic          w_full;
    logic          w_empty;
    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_grant_wr;
    logic          w_grant_rd;

    wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (bus.flush),
        .i_inc   (w_grant_wr),
        .o_ptr   (w_wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (bus.flush),
        .i_inc   (w_grant_rd),
        .o_ptr   (w_rd_ptr)
    );

    // Next state is the grant for the current cycle: it depends only on the
    // present inputs, the occupancy and who was served last.
    always_comb begin
        w_full       = (r_count == C_DEPTH);
        w_empty      = (r_count == '0);
        w_wr_elig    = bus.wr_valid & ~w_full;
        w_rd_elig    = bus.rd_req & ~w_empty;
        w_next_state = ST_IDLE;
        if (!bus.flush) begin
            if (w_wr_elig && w_rd_elig) begin
                w_next_state = (r_last_grant == GNT_RD) ? ST_GNT_WR : ST_GNT_RD;
            end else if (w_wr_elig) begin
                w_next_state = ST_GNT_WR;
            end else if (w_rd_elig) begin
                w_next_state = ST_GNT_RD;
            end
        end
        w_grant    = state_to_grant(w_next_state);
        w_grant_wr = (w_grant == GNT_WR);
        w_grant_rd = (w_grant == GNT_RD);

        // Address/data hold their previous value when idle to avoid toggling
        // the wide memory bus needlessly.
        w_mem_addr  = r_addr_q;
        w_mem_wdata = r_wdata_q;
        if (w_grant_wr) begin
            w_mem_addr  = w_wr_ptr;
            w_mem_wdata = bus.wr_data;
        end else if (w_grant_rd) begin
            w_mem_addr  = w_rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GNT_RD;
            r_count      <= '0;
            r_ovf_err    <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
        end else begin
            r_addr_q  <= w_mem_addr;
            r_wdata_q <= w_mem_wdata;
            if (bus.flush && bus.wr_valid) begin
                r_ovf_err <= 1'b1;
            end
            if (bus.flush) begin
                r_last_grant <= GNT_RD;
                r_count      <= '0;
            end else if (w_grant_wr) begin
                r_last_grant <= GNT_WR;
                r_count      <= r_count + 1'b1;
            end else if (w_grant_rd) begin
                r_last_grant <= GNT_RD;
                r_count      <= r_count - 1'b1;
            end
        end
    end

    // The registered state doubles as the one-cycle-delayed read grant, so a
    // read granted just before a flush still reports its data.
    assign bus.rd_valid  = (r_state == ST_GNT_RD);
    assign bus.rd_data   = bus.mem_rdata;
    assign bus.wr_ready  = w_grant_wr;
    assign bus.mem_en    = w_grant_wr | w_grant_rd;
    assign bus.mem_we    = w_grant_wr;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.ovf_err   = r_ovf_err;
endmodule
`default_nettype wire
